// File: rtl/smg_fifo_sched.sv
// rtl/smg_fifo_sched.sv - FIFO-fed six-digit seven-segment scheduler; SMG_SCROLL_EN enables a three-byte scrolling window.
module smg_fifo_sched #(
    parameter int SCAN_DIV    = 50000,
    parameter int DWELL_TICKS = 1000
) (
    input  logic       clk_50MHz,
    input  logic       rst,
    input  logic       fifo_empty,
    output logic       fifo_rd_en,
    input  logic [7:0] fifo_dout,
    input  logic       pause,
    output logic [5:0] smg_sig,
    output logic [7:0] smg_data
);

    localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int DW = $clog2(DWELL_TICKS + 1);
    localparam logic [SW-1:0] SCAN_LAST  = SW'(SCAN_DIV - 1);
    localparam logic [DW-1:0] DWELL_LAST = DW'(DWELL_TICKS);

    typedef enum logic [1:0] {IDLE, RD, CAP, HOLD} state_t;

    state_t        state, state_nxt;
    logic [SW-1:0] scan_cnt;
    logic          scan_tick;
    logic [2:0]    dig_idx, dig_nxt;
    logic [7:0]    digit;
    logic [DW-1:0] dwell_cnt;
    logic          dwell_done;
    logic          rd_done;
    logic [7:0]    b0, b1, b2;
    logic          v0, v1, v2;

    function automatic logic [7:0] seg_hex(input logic [3:0] n);
        case (n)
            4'h0: seg_hex = 8'hC0;
            4'h1: seg_hex = 8'hF9;
            4'h2: seg_hex = 8'hA4;
            4'h3: seg_hex = 8'hB0;
            4'h4: seg_hex = 8'h99;
            4'h5: seg_hex = 8'h92;
            4'h6: seg_hex = 8'h82;
            4'h7: seg_hex = 8'hF8;
            4'h8: seg_hex = 8'h80;
            4'h9: seg_hex = 8'h90;
            4'hA: seg_hex = 8'h88;
            4'hB: seg_hex = 8'h83;
            4'hC: seg_hex = 8'hC6;
            4'hD: seg_hex = 8'hA1;
            4'hE: seg_hex = 8'h86;
            default: seg_hex = 8'h8E;
        endcase
    endfunction

    assign scan_tick = (scan_cnt == SCAN_LAST);

    // The read strobe is gated by fifo_empty so an empty FIFO is never popped.
    always_comb begin
        state_nxt  = state;
        fifo_rd_en = 1'b0;
        case (state)
            IDLE: if (dwell_done && !fifo_empty && !pause) state_nxt = RD;
            RD: begin
                fifo_rd_en = !fifo_empty;
                state_nxt  = CAP;
            end
            CAP:  state_nxt = HOLD;
            HOLD: if (dwell_cnt == DWELL_LAST) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk_50MHz or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            dwell_cnt  <= '0;
            dwell_done <= 1'b1;
            rd_done    <= 1'b0;
            b0 <= 8'h00; b1 <= 8'h00; b2 <= 8'h00;
            v0 <= 1'b0;  v1 <= 1'b0;  v2 <= 1'b0;
        end else begin
            state <= state_nxt;
            case (state)
                RD: rd_done <= fifo_rd_en;
                CAP: begin
                    dwell_done <= 1'b0;
                    dwell_cnt  <= '0;
                    if (rd_done) begin
`ifdef SMG_SCROLL_EN
                        b2 <= b1; v2 <= v1;
                        b1 <= b0; v1 <= v0;
`endif
                        b0 <= fifo_dout;
                        v0 <= 1'b1;
                    end
                end
                HOLD: begin
                    if (dwell_cnt == DWELL_LAST) dwell_done <= 1'b1;
                    else if (scan_tick)          dwell_cnt  <= dwell_cnt + 1'b1;
                end
                default: ;
            endcase
        end
    end

    // Digit content is sampled from the window at the tick, so a byte captured
    // on the same edge only appears from the next tick onward.
    always_comb begin
        dig_nxt = (dig_idx == 3'd5) ? 3'd0 : dig_idx + 3'd1;
        digit   = 8'hFF;
        case (dig_nxt)
            3'd0: if (v0) digit = seg_hex(b0[3:0]);
            3'd1: if (v0) digit = seg_hex(b0[7:4]);
            3'd2: if (v1) digit = seg_hex(b1[3:0]);
            3'd3: if (v1) digit = seg_hex(b1[7:4]);
            3'd4: if (v2) digit = seg_hex(b2[3:0]);
            3'd5: if (v2) digit = seg_hex(b2[7:4]);
            default: digit = 8'hFF;
        endcase
        if (dig_nxt == 3'd0 && pause) digit[7] = 1'b0;
    end

    always_ff @(posedge clk_50MHz or negedge rst) begin
        if (!rst) begin
            scan_cnt <= '0;
            dig_idx  <= 3'd0;
            smg_sig  <= 6'b111111;
            smg_data <= 8'hFF;
        end else begin
            scan_cnt <= scan_tick ? '0 : scan_cnt + 1'b1;
            if (scan_tick) begin
                dig_idx  <= dig_nxt;
                smg_sig  <= ~(6'b000001 << dig_nxt);
                smg_data <= digit;
            end
        end
    end

endmodule

// File: tb/tb_smg_fifo_sched.sv
// tb/tb_smg_fifo_sched.sv - randomized self-checking bench for smg_fifo_sched against a timestamp reference model.
`timescale 1ns/1ps
module tb_smg_fifo_sched;

    localparam int SD = 4;
    localparam int DT = 3;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       fifo_empty = 1'b1;
    logic       fifo_rd_en;
    logic [7:0] fifo_dout = 8'h00;
    logic       pause = 1'b0;
    logic [5:0] smg_sig;
    logic [7:0] smg_data;

    smg_fifo_sched #(.SCAN_DIV(SD), .DWELL_TICKS(DT)) dut (
        .clk_50MHz (clk),
        .rst       (rst),
        .fifo_empty(fifo_empty),
        .fifo_rd_en(fifo_rd_en),
        .fifo_dout (fifo_dout),
        .pause     (pause),
        .smg_sig   (smg_sig),
        .smg_data  (smg_data)
    );

    always #10 clk = ~clk;

    int checks = 0;
    int failures = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    logic [7:0] q[$];
    logic       stall = 1'b0;

    always @(posedge clk)
        if (rst && fifo_rd_en && q.size() > 0) fifo_dout <= q.pop_front();

    logic [7:0] seg_tab[16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                                8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

    // Reference model: cycle k counts from reset release; reads are scheduled by timestamps.
    int         k, plan_rd, idle_from, ntick, rd_cnt, last_rd, last_d0;
    logic [7:0] win[3];
    bit         wv[3];
    logic [7:0] pend;
    bit         pend_v;
    logic [5:0] e_sig, prev_sig;
    logic [7:0] e_data;
    logic [7:0] obs[6];

    function automatic logic [7:0] exp_digit(input int d);
        logic [7:0] b;
        if (!wv[d/2]) return 8'hFF;
        b = win[d/2];
        return (d % 2) ? seg_tab[b[7:4]] : seg_tab[b[3:0]];
    endfunction

    task automatic model_reset();
        k = 0; plan_rd = -100; idle_from = 0; ntick = 0; pend_v = 0;
        last_d0 = -1; prev_sig = 6'h3F;
        for (int i = 0; i < 3; i++) begin win[i] = 8'h00; wv[i] = 0; end
        e_sig = 6'h3F; e_data = 8'hFF;
    endtask

    task automatic clear_obs();
        for (int i = 0; i < 6; i++) obs[i] = 8'hFF;
    endtask

    task automatic step();
        int cap, j0;
        fifo_empty = stall || (q.size() == 0);
        #1;
        check_eq("rd_en", fifo_rd_en, (k == plan_rd) && !fifo_empty);
        check_eq("smg_sig", smg_sig, e_sig);
        check_eq("smg_data", smg_data, e_data);
        if (fifo_rd_en) begin rd_cnt++; last_rd = k; end
        for (int d = 0; d < 6; d++) if (smg_sig == ~(6'd1 << d)) obs[d] = smg_data;
        if (smg_sig == 6'h3E && prev_sig != 6'h3E) begin
            if (last_d0 >= 0) check_eq("scan_wrap", k - last_d0, 24);
            last_d0 = k;
        end
        prev_sig = smg_sig;
        if (k == plan_rd) begin
            pend_v = !fifo_empty;
            if (pend_v) pend = q[0];
        end
        if (k % SD == SD - 1) begin
            ntick++;
            e_sig  = ~(6'd1 << (ntick % 6));
            e_data = exp_digit(ntick % 6);
            if (ntick % 6 == 0 && pause) e_data[7] = 1'b0;
        end
        if (k == plan_rd + 1 && pend_v) begin
`ifdef SMG_SCROLL_EN
            win[2] = win[1]; wv[2] = wv[1];
            win[1] = win[0]; wv[1] = wv[0];
`endif
            win[0] = pend; wv[0] = 1;
        end
        if (k >= idle_from && !fifo_empty && !pause) begin
            plan_rd   = k + 1;
            cap       = k + 2;
            j0        = cap + 1 + (SD - 1 - (cap + 1) % SD);
            idle_from = j0 + (DT - 1) * SD + 2;
        end
        k++;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    int first_rd, second_rd, base_cnt, k_unpause, budget;

    initial begin
        model_reset();
        rd_cnt = 0; last_rd = -1;
        repeat (3) @(negedge clk);
        #1;
        check_eq("rst_sig", smg_sig, 6'h3F);
        check_eq("rst_data", smg_data, 8'hFF);
        check_eq("rst_rd_en", fifo_rd_en, 0);

        // Two preloaded bytes from reset: latency, dwell spacing and final window.
        q.push_back(8'h3C); q.push_back(8'hA5);
        @(negedge clk); rst = 1'b1;
        first_rd = -1; second_rd = -1;
        for (int i = 0; i < 30; i++) begin
            base_cnt = rd_cnt;
            step();
            if (rd_cnt != base_cnt) begin
                if (first_rd < 0) first_rd = last_rd; else if (second_rd < 0) second_rd = last_rd;
            end
        end
        check_eq("first_rd_cycle", first_rd, 1);
        check_eq("rd_gap_after_cap", second_rd - (first_rd + 1), 12);
        clear_obs();
        run(30);
        check_eq("dig0", obs[0], 8'h92);
        check_eq("dig1", obs[1], 8'h88);
`ifdef SMG_SCROLL_EN
        check_eq("dig2", obs[2], 8'hC6);
        check_eq("dig3", obs[3], 8'hB0);
`else
        check_eq("dig2", obs[2], 8'hFF);
        check_eq("dig3", obs[3], 8'hFF);
`endif
        check_eq("dig4", obs[4], 8'hFF);
        check_eq("dig5", obs[5], 8'hFF);

        // Pause blocks reads and lights dp on digit 0; release reads on the next cycle.
        q.push_back(8'h5A); pause = 1'b1;
        base_cnt = rd_cnt; clear_obs();
        run(100);
        check_eq("pause_no_rd", rd_cnt - base_cnt, 0);
        check_eq("pause_dp", obs[0][7], 0);
        pause = 1'b0; k_unpause = k;
        run(3);
        check_eq("unpause_rd", last_rd, k_unpause + 1);

        // Empty FIFO: no reads, display holds the last byte.
        base_cnt = rd_cnt;
        run(10); clear_obs(); run(40);
        check_eq("empty_no_rd", rd_cnt - base_cnt, 0);
        check_eq("hold_dig0", obs[0], 8'h88);
        check_eq("hold_dig1", obs[1], 8'h92);

        // Random traffic with pause and transient empty.
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(15) == 0) pause = ~pause;
            if ($urandom_range(9) == 0) stall = ~stall;
            if ($urandom_range(5) == 0 && q.size() < 8) q.push_back(8'($urandom));
            step();
        end
        pause = 1'b0; stall = 1'b0;

        // Reset in the RD cycle drops the strobe at once and discards the byte.
        q.push_back(8'hE7);
        budget = 200;
        while (k != plan_rd && budget > 0) begin step(); budget--; end
        check_eq("rd_reached", budget > 0, 1);
        fifo_empty = stall || (q.size() == 0);
        #1;
        check_eq("rd_before_rst", fifo_rd_en, 1);
        rst = 1'b0;
        #1;
        check_eq("rst_mid_rd_en", fifo_rd_en, 0);
        check_eq("rst_mid_sig", smg_sig, 6'h3F);
        check_eq("rst_mid_data", smg_data, 8'hFF);
        q.delete();
        @(negedge clk); @(negedge clk);
        rst = 1'b1;
        model_reset();
        clear_obs();
        run(60);
        check_eq("discard_dig0", obs[0], 8'hFF);
        check_eq("discard_dig1", obs[1], 8'hFF);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/smg_fifo_sched.md
SMG_FIFO_SCHED -- requirements
Module: smg_fifo_sched

Interface
REQ-001 SHALL have parameter SCAN_DIV, default 50000, clk_50MHz cycles per digit-scan tick (1 kHz scan).
REQ-002 SHALL have parameter DWELL_TICKS, default 1000, scan ticks a byte is held before the next FIFO read (1 s).
REQ-003 SHALL have port clk_50MHz  input  1  system clock; all logic on its rising edge.
REQ-004 SHALL have port rst  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port fifo_empty  input  1  upstream FIFO empty flag.
REQ-006 SHALL have port fifo_rd_en  output  1  one-cycle FIFO read strobe.
REQ-007 SHALL have port fifo_dout  input  8  FIFO read data, valid the cycle after fifo_rd_en.
REQ-008 SHALL have port pause  input  1  level; 1 inhibits new FIFO reads.
REQ-009 SHALL have port smg_sig  output  6  active-low digit select; bit0 = rightmost digit.
REQ-010 SHALL have port smg_data  output  8  active-low segments a..g on bits 0..6, dp on bit7.

Function
REQ-011 SHALL count clk_50MHz cycles 0..SCAN_DIV-1 and emit a one-cycle scan tick at SCAN_DIV-1, then wrap to 0.
REQ-012 SHALL advance the digit index 0,1,..,5,0 on each scan tick; smg_sig and smg_data are registered and change the cycle after the tick.
REQ-013 SHALL drive exactly one smg_sig bit low at a time after the first scan tick.
REQ-014 SHALL encode hex nibbles: 0=C0 1=F9 2=A4 3=B0 4=99 5=92 6=82 7=F8 8=80 9=90 A=88 b=83 C=C6 d=A1 E=86 F=8E; blank=FF.
REQ-015 SHALL run a read FSM with states IDLE, RD, CAP, HOLD.
REQ-016 IDLE->RD when dwell_done=1, fifo_empty=0 and pause=0, all sampled in the same cycle.
REQ-017 RD SHALL assert fifo_rd_en for exactly one cycle, then go to CAP unconditionally.
REQ-018 CAP SHALL latch fifo_dout into the display window, set valid, clear dwell_done, zero the dwell counter, and go to HOLD.
REQ-019 HOLD SHALL count scan ticks; at DWELL_TICKS ticks it sets dwell_done and returns to IDLE.
REQ-020 dwell_done SHALL be 1 out of reset, so the first available byte is read without delay.
REQ-021 fifo_rd_en SHALL never assert while fifo_empty=1 in the same cycle.
REQ-022 pause asserted during RD, CAP or HOLD SHALL NOT abort the sequence; it only blocks the IDLE->RD transition.
REQ-023 A byte slot that has never been loaded SHALL display blank (FF) on both its digits.
REQ-024 Digit 0 SHALL show the low nibble of byte b0 and digit 1 its high nibble; with pause=1, digit 0 additionally drives dp low (bit7=0).
REQ-025 A scan tick coinciding with CAP SHALL display the newly captured byte from the following tick onward; there SHALL be no mixed old/new nibbles on a single digit.

Reset
REQ-026 While rst=0, outputs SHALL be: smg_sig=6'b111111, smg_data=8'hFF, fifo_rd_en=0.
REQ-027 While rst=0, the FSM SHALL be IDLE with counters 0, digit index 0, all window bytes 00 and invalid, and dwell_done=1.
REQ-028 Reset asserted mid-RD or mid-CAP SHALL drop fifo_rd_en immediately and discard the in-flight byte.

Configuration
REQ-029 SHALL honour macro SMG_SCROLL_EN.
REQ-030 With SMG_SCROLL_EN defined, CAP SHALL shift b1->b2, b0->b1 and new->b0, with valid bits shifted alongside; digits 3:2 show b1 and digits 5:4 show b2.
REQ-031 Without SMG_SCROLL_EN, CAP SHALL overwrite b0 only, and digits 5:2 SHALL stay blank (FF) while still being scanned.

Verification (SCAN_DIV=4, DWELL_TICKS=3)
REQ-032 Reset release, FIFO preloaded with 3C -> fifo_rd_en for 1 cycle within 2 cycles; digit0=C6, digit1=B0; digits 5:2 = FF.
REQ-033 Bytes 3C, A5 with SMG_SCROLL_EN -> second rd_en exactly 12 cycles after first CAP; afterwards digit0=92, digit1=88, digit2=C6, digit3=B0.
REQ-034 Same stimulus without SMG_SCROLL_EN -> digit0=92, digit1=88, digits 5:2 = FF.
REQ-035 pause=1 with FIFO non-empty and dwell elapsed -> no fifo_rd_en for 100 cycles and digit0 bit7=0; pause=0 -> rd_en on the next cycle.
REQ-036 fifo_empty=1 for 50 cycles -> fifo_rd_en stays 0 and the display holds its last byte; the scan index wraps 5->0 every 24 cycles.
REQ-037 rst pulled low in the RD cycle -> fifo_rd_en=0 the same cycle, all outputs at reset values, and the in-flight byte never displayed.
